regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_write_arbiter_if.sv | 42 ++++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 99 +++++++++
 tb/tb_regfile_write_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write path.
package regfile_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 64;
  localparam int NUM_REGS       = 32;
  localparam int ZERO_REG       = 31;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester and register-file side signals of the write arbiter.
// Bypass read-forwarding signals exist only when REGFILE_WR_BYPASS_EN is defined.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rf_ready;
  logic                          rf_wr_en;
  logic [ADDR_WIDTH-1:0]         rf_wr_addr;
  logic [DATA_WIDTH-1:0]         rf_wr_data;
  logic                          busy;
`ifdef REGFILE_WR_BYPASS_EN
  logic [ADDR_WIDTH-1:0]         byp_rd_addr;
  logic                          byp_hit;
  logic [DATA_WIDTH-1:0]         byp_data;
`endif

  modport master (
    output req_valid, req_addr, req_data, rf_ready,
`ifdef REGFILE_WR_BYPASS_EN
    output byp_rd_addr,
    input  byp_hit, byp_data,
`endif
    input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, rf_ready,
`ifdef REGFILE_WR_BYPASS_EN
    input  byp_rd_addr,
    output byp_hit, byp_data,
`endif
    output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data, busy
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, searching upward cyclically.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter feeding a one-entry write stage for the register file write port.
// Optional read-forwarding outputs are enabled by defining REGFILE_WR_BYPASS_EN.
//
// state | meaning
// IDLE  | stage empty, rf_wr_en low
// WRITE | stage holds a pending write, rf_wr_en high
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = regfile_pkg::REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::REG_ADDR_WIDTH,
  parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
  input logic                     clk,
  input logic                     reset_n,
  regfile_write_arbiter_if.slave  wr
);
  import regfile_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wr_state_t             state;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  free;
  logic                  xfer;

  assign free = (state == IDLE) | (wr.rf_wr_en & wr.rf_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_arbiter (
    .req   (wr.req_valid),
    .ptr   (ptr),
    .en    (free),
    .grant (grant)
  );

  assign wr.req_ready = grant;
  assign xfer         = |grant;
  assign wr.busy      = (state == WRITE);

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx  = PTR_W'(i);
        win_addr = wr.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_data = wr.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign next_ptr = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);

  // Zero-register writes are consumed like any other grant but never raise the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      wr.rf_wr_en   <= 1'b0;
      wr.rf_wr_addr <= '0;
      wr.rf_wr_data <= '0;
    end else if (xfer) begin
      ptr           <= next_ptr;
      wr.rf_wr_addr <= win_addr;
      wr.rf_wr_data <= win_data;
      if (win_addr == ADDR_WIDTH'(ZERO_REG)) begin
        state       <= IDLE;
        wr.rf_wr_en <= 1'b0;
      end else begin
        state       <= WRITE;
        wr.rf_wr_en <= 1'b1;
      end
    end else if (state == WRITE && wr.rf_ready) begin
      state       <= IDLE;
      wr.rf_wr_en <= 1'b0;
    end
  end

`ifdef REGFILE_WR_BYPASS_EN
  assign wr.byp_hit  = (state == WRITE) & (wr.rf_wr_addr == wr.byp_rd_addr);
  assign wr.byp_data = wr.rf_wr_data;
`endif

`ifndef SYNTHESIS
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_hold
    a_req_hold : assert property (@(posedge clk) disable iff (!reset_n)
      (wr.req_valid[g] && !wr.req_ready[g]) |=>
        (wr.req_valid[g] &&
         $stable(wr.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]) &&
         $stable(wr.req_data[g*DATA_WIDTH +: DATA_WIDTH])));
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; bypass checks compile in with REGFILE_WR_BYPASS_EN.
module tb_regfile_write_arbiter;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;

  regfile_write_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

  regfile_write_arbiter u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    bus.req_valid[i]         = v;
    bus.req_addr[i*5 +: 5]   = a;
    bus.req_data[i*64 +: 64] = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rf_ready  = 1'b1;
`ifdef REGFILE_WR_BYPASS_EN
    bus.byp_rd_addr = '0;
`endif
    step(); step();
    reset_n = 1'b1;
    settle();
    chk("rst_en",   64'(bus.rf_wr_en),   64'd0);
    chk("rst_busy", 64'(bus.busy),       64'd0);
    chk("rst_addr", 64'(bus.rf_wr_addr), 64'd0);
    chk("rst_data", bus.rf_wr_data,      64'd0);

    for (int c = 0; c < 10; c++) begin
      step(); settle();
      chk("idle_en",    64'(bus.rf_wr_en),  64'd0);
      chk("idle_busy",  64'(bus.busy),      64'd0);
      chk("idle_ready", 64'(bus.req_ready), 64'd0);
    end

    // single write from requester 0
    step();
    set_req(0, 1'b1, 5'd5, 64'hDEADBEEF_00000001);
    settle();
    chk("sw_ready", 64'(bus.req_ready), 64'b001);
    step();
    set_req(0, 1'b0, 5'd0, 64'd0);
    settle();
    chk("sw_en",   64'(bus.rf_wr_en),   64'd1);
    chk("sw_addr", 64'(bus.rf_wr_addr), 64'd5);
    chk("sw_data", bus.rf_wr_data,      64'hDEADBEEF_00000001);
    chk("sw_busy", 64'(bus.busy),       64'd1);
    step(); settle();
    chk("sw_busy_clr", 64'(bus.busy),     64'd0);
    chk("sw_en_clr",   64'(bus.rf_wr_en), 64'd0);

    // asynchronous reset while a write is pending
    step();
    set_req(0, 1'b1, 5'd4, 64'h44);
    settle();
    step();
    set_req(0, 1'b0, 5'd0, 64'd0);
    settle();
    chk("mid_en_pre", 64'(bus.rf_wr_en), 64'd1);
    reset_n = 1'b0;
    settle();
    chk("mid_en_async", 64'(bus.rf_wr_en), 64'd0);
    chk("mid_busy",     64'(bus.busy),     64'd0);
    step();
    reset_n = 1'b1;

    // round robin, pointer back at 0 after reset
    step();
    set_req(0, 1'b1, 5'd1, 64'h101);
    set_req(1, 1'b1, 5'd2, 64'h102);
    set_req(2, 1'b1, 5'd3, 64'h103);
    settle();
    chk("rr_g0", 64'(bus.req_ready), 64'b001);
    step(); settle();
    chk("rr_g1",   64'(bus.req_ready),  64'b010);
    chk("rr_a1",   64'(bus.rf_wr_addr), 64'd1);
    step(); settle();
    chk("rr_g2",   64'(bus.req_ready),  64'b100);
    chk("rr_a2",   64'(bus.rf_wr_addr), 64'd2);
    step(); settle();
    chk("rr_g3",   64'(bus.req_ready),  64'b001);
    chk("rr_a3",   64'(bus.rf_wr_addr), 64'd3);
    chk("rr_en3",  64'(bus.rf_wr_en),   64'd1);
    step();
    set_req(0, 1'b0, 5'd0, 64'd0);
    settle();
    chk("rr_g4",   64'(bus.req_ready),  64'b010);
    chk("rr_a4",   64'(bus.rf_wr_addr), 64'd1);
    chk("rr_d4",   bus.rf_wr_data,      64'h101);
    step();
    set_req(1, 1'b0, 5'd0, 64'd0);
    settle();
    chk("rr_g5",   64'(bus.req_ready),  64'b100);
    chk("rr_a5",   64'(bus.rf_wr_addr), 64'd2);
    step();
    set_req(2, 1'b0, 5'd0, 64'd0);
    settle();
    chk("rr_g6",   64'(bus.req_ready),  64'b000);
    chk("rr_a6",   64'(bus.rf_wr_addr), 64'd3);
    chk("rr_en6",  64'(bus.rf_wr_en),   64'd1);
    step(); settle();
    chk("rr_en7",  64'(bus.rf_wr_en),   64'd0);

    // stall with a write to register 7 pending and requester 1 waiting
    step();
    set_req(0, 1'b1, 5'd7, 64'h7777);
    settle();
    chk("st_g0", 64'(bus.req_ready), 64'b001);
    step();
    set_req(0, 1'b0, 5'd0, 64'd0);
    set_req(1, 1'b1, 5'd8, 64'h8888);
    bus.rf_ready = 1'b0;
    settle();
    for (int c = 0; c < 4; c++) begin
      chk("st_ready", 64'(bus.req_ready),  64'b000);
      chk("st_en",    64'(bus.rf_wr_en),   64'd1);
      chk("st_addr",  64'(bus.rf_wr_addr), 64'd7);
      chk("st_data",  bus.rf_wr_data,      64'h7777);
      if (c < 3) begin
        step(); settle();
      end
    end
    step();
    bus.rf_ready = 1'b1;
    settle();
    chk("st_rel_g",    64'(bus.req_ready),  64'b010);
    chk("st_rel_addr", 64'(bus.rf_wr_addr), 64'd7);
    step();
    set_req(1, 1'b0, 5'd0, 64'd0);
    settle();
    chk("st_nx_en",   64'(bus.rf_wr_en),   64'd1);
    chk("st_nx_addr", 64'(bus.rf_wr_addr), 64'd8);
    chk("st_nx_data", bus.rf_wr_data,      64'h8888);
    step(); settle();
    chk("st_en_clr", 64'(bus.rf_wr_en), 64'd0);

    // requester 2 write returns the pointer to 0
    step();
    set_req(2, 1'b1, 5'd12, 64'hC);
    settle();
    chk("r2_g", 64'(bus.req_ready), 64'b100);
    step();
    set_req(2, 1'b0, 5'd0, 64'd0);
    settle();
    chk("r2_addr", 64'(bus.rf_wr_addr), 64'd12);
    chk("r2_data", bus.rf_wr_data,      64'hC);
    step(); settle();

    // zero-register write: granted, no strobe, pointer moves to 2
    step();
    set_req(1, 1'b1, 5'd31, 64'h31);
    settle();
    chk("z_g", 64'(bus.req_ready), 64'b010);
    step();
    set_req(1, 1'b0, 5'd0, 64'd0);
    set_req(0, 1'b1, 5'd10, 64'hA);
    set_req(2, 1'b1, 5'd14, 64'hE);
    settle();
    chk("z_en",   64'(bus.rf_wr_en),  64'd0);
    chk("z_busy", 64'(bus.busy),      64'd0);
    chk("z_ptr",  64'(bus.req_ready), 64'b100);
    step();
    set_req(2, 1'b0, 5'd0, 64'd0);
    settle();
    chk("z_a14", 64'(bus.rf_wr_addr), 64'd14);
    chk("z_g0",  64'(bus.req_ready),  64'b001);
    step();
    set_req(0, 1'b0, 5'd0, 64'd0);
    settle();
    chk("z_a10", 64'(bus.rf_wr_addr), 64'd10);
    chk("z_d10", bus.rf_wr_data,      64'hA);
    step(); settle();
    chk("z_en_clr", 64'(bus.rf_wr_en), 64'd0);

`ifdef REGFILE_WR_BYPASS_EN
    step();
    set_req(0, 1'b1, 5'd9, 64'h99);
    bus.byp_rd_addr = 5'd9;
    settle();
    chk("byp_idle", 64'(bus.byp_hit), 64'd0);
    step();
    set_req(0, 1'b0, 5'd0, 64'd0);
    bus.rf_ready = 1'b0;
    settle();
    chk("byp_hit",  64'(bus.byp_hit), 64'd1);
    chk("byp_data", bus.byp_data,     64'h99);
    bus.byp_rd_addr = 5'd10;
    settle();
    chk("byp_miss", 64'(bus.byp_hit), 64'd0);
    bus.byp_rd_addr = 5'd9;
    step();
    bus.rf_ready = 1'b1;
    step(); settle();
    chk("byp_done", 64'(bus.byp_hit), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
